alu_chain_ctrl: RTL and testbench

ALU_CHAIN_CTRL -- requirements
Module: alu_chain_ctrl

---
 rtl/alu_chain_ctrl_if.sv | 46 ++++
 rtl/alu_chain_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_chain_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_chain_ctrl_if
// Description : Bundles the host request/response and ALU word signals of
//               alu_chain_ctrl.
//               Host side : start, op, opA, opB -> busy, done, result,
//                           carry_out, zero
//               ALU side  : alu_a, alu_b, alu_ctrl, alu_flag_in -> alu_y,
//                           alu_flags {C, Z}
//               slave  : the chain controller
//               master : the host plus the external ALU
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_chain_ctrl_if #(
    parameter int N = 8,
    parameter int W = 4
);
    logic             start;
    logic             op;
    logic [N*W-1:0]   opA;
    logic [N*W-1:0]   opB;
    logic             busy;
    logic             done;
    logic [N*W-1:0]   result;
    logic             carry_out;
    logic             zero;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_ctrl;
    logic             alu_flag_in;
    logic [N-1:0]     alu_y;
    logic [1:0]       alu_flags;

    modport slave (
        input  start, op, opA, opB, alu_y, alu_flags,
        output busy, done, result, carry_out, zero,
               alu_a, alu_b, alu_ctrl, alu_flag_in
    );

    modport master (
        output start, op, opA, opB, alu_y, alu_flags,
        input  busy, done, result, carry_out, zero,
               alu_a, alu_b, alu_ctrl, alu_flag_in
    );
endinterface
`default_nettype wire

// File: rtl/alu_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_chain_ctrl
// Description : Performs an N*W-bit add or subtract by sequencing an external
//               N-bit ALU one word per cycle, LSW first, chaining the carry.
//               Ports:
//                 clk   - rising-edge clock
//                 rst_n - asynchronous active-low reset (release synchronised)
//                 bus   - alu_chain_ctrl_if.slave (host + ALU signals)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_chain_ctrl #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_chain_ctrl_if.slave  bus
);
    localparam int              c_IW       = $clog2(W);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(W - 1);
    localparam logic [3:0]      c_CTRL_ADD = 4'h3;
    localparam logic [3:0]      c_CTRL_SUB = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reset asserts immediately; release passes through two flops so every
    // downstream flop leaves reset on the same clean edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_t            r_state;
    state_t            w_next;
    logic [c_IW-1:0]   r_idx;
    logic              r_cr;
    logic              r_za;
    logic              r_op;
    logic [N*W-1:0]    r_a;
    logic [N*W-1:0]    r_b;
    logic [N*W-1:0]    r_result;
    logic              r_carry_out;
    logic              r_zero;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_ctrl    = 4'h0;
        bus.alu_flag_in = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
            end
            S_RUN: begin
                bus.busy        = 1'b1;
                bus.alu_a       = r_a[int'(r_idx)*N +: N];
                bus.alu_b       = r_b[int'(r_idx)*N +: N];
                bus.alu_ctrl    = r_op ? c_CTRL_SUB : c_CTRL_ADD;
                bus.alu_flag_in = r_cr;
                if (r_idx == c_IDX_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_idx       <= '0;
            r_cr        <= 1'b0;
            r_za        <= 1'b1;
            r_op        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.opA;
                        r_b   <= bus.opB;
                        r_op  <= bus.op;
                        r_idx <= '0;
                        // Subtract is A + ~B + 1, so the chain starts with carry=1.
                        r_cr  <= bus.op;
                        r_za  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_result[int'(r_idx)*N +: N] <= bus.alu_y;
                    r_cr <= bus.alu_flags[1];
                    r_za <= r_za & bus.alu_flags[0];
                    if (r_idx == c_IDX_LAST) begin
                        r_idx       <= '0;
                        // Published separately so flags hold through the
                        // next start and reset to 0 while za resets to 1.
                        r_carry_out <= bus.alu_flags[1];
                        r_zero      <= r_za & bus.alu_flags[0];
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_chain_ctrl
// Description : Directed self-checking bench for alu_chain_ctrl (N=8, W=4)
//               with a behavioural model of the team ALU attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_chain_ctrl;
    localparam int N = 8;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_chain_ctrl_if #(.N(N), .W(W)) bus ();

    alu_chain_ctrl #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team ALU: 3 = add with carry, 4 = A + ~B + carry; flags {C, Z}.
    logic [N:0] w_alu_sum;
    always_comb begin
        w_alu_sum = '0;
        case (bus.alu_ctrl)
            4'h3:    w_alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{N{1'b0}}, bus.alu_flag_in};
            4'h4:    w_alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{N{1'b0}}, bus.alu_flag_in};
            default: w_alu_sum = '0;
        endcase
        bus.alu_y     = w_alu_sum[N-1:0];
        bus.alu_flags = {w_alu_sum[N], (w_alu_sum[N-1:0] == '0)};
    end

    // Runs one operation for ten sample points starting one step after the
    // start edge. mode 1 re-asserts start and flips opA/op during RUN and DONE.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int mode, output logic [31:0] res, output logic co,
                         output logic z, output int done_k, output int done_cnt,
                         output int busy_cnt, output int ctrl_bad);
        logic [3:0] exp_ctrl;
        exp_ctrl = op ? 4'h4 : 4'h3;
        done_k = -1; done_cnt = 0; busy_cnt = 0; ctrl_bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (bus.busy && !bus.done && bus.alu_ctrl !== exp_ctrl) ctrl_bad++;
            if (mode == 1) begin
                if (k == 1) begin bus.start = 1'b1; bus.opA = ~a; bus.op = ~op; end
                if (k == 2) bus.start = 1'b0;
                if (k == 4) bus.start = 1'b1;
                if (k == 5) begin bus.start = 1'b0; bus.opA = a; bus.op = op; end
            end
        end
        res = bus.result; co = bus.carry_out; z = bus.zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 1'b0; bus.opA = '0; bus.opB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.carry_out, bus.zero} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.carry_out, bus.zero});
        end
        checks++;
        if (bus.result !== 32'h0) begin
            errors++; $display("FAIL reset_result got %h want 00000000", bus.result);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_flag_in} !== 21'h0) begin
            errors++; $display("FAIL reset_alu got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_flag_in});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_add();
        logic [31:0] res; logic co, z; int dk, dc, bc, cb;
        do_op(1'b0, 32'h000000FF, 32'h00000001, 0, res, co, z, dk, dc, bc, cb);
        checks++;
        if ({res, co, z} !== {32'h00000100, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_ff_1 got %h c=%b z=%b want 00000100 c=0 z=0", res, co, z);
        end
        checks++;
        if (dk !== W || dc !== 1) begin
            errors++; $display("FAIL add_latency got done_at=%0d pulses=%0d want %0d/1", dk, dc, W);
        end
        checks++;
        if (bc !== W + 1) begin
            errors++; $display("FAIL add_busy_cycles got %0d want %0d", bc, W + 1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_flag_in} !== 21'h0 || bus.result !== 32'h00000100) begin
            errors++; $display("FAIL idle_hold got alu=%h res=%h want 0/00000100",
                               {bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_flag_in}, bus.result);
        end
        do_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 0, res, co, z, dk, dc, bc, cb);
        checks++;
        if ({res, co, z} !== {32'h00000000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL add_wrap got %h c=%b z=%b want 00000000 c=1 z=1", res, co, z);
        end
    endtask

    task automatic test_sub();
        logic [31:0] res; logic co, z; int dk, dc, bc, cb;
        do_op(1'b1, 32'h00010000, 32'h00000001, 0, res, co, z, dk, dc, bc, cb);
        checks++;
        if ({res, co, z} !== {32'h0000FFFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sub_borrow_chain got %h c=%b z=%b want 0000ffff c=1 z=0", res, co, z);
        end
        do_op(1'b1, 32'h00000001, 32'h00000002, 0, res, co, z, dk, dc, bc, cb);
        checks++;
        if ({res, co, z} !== {32'hFFFFFFFF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_negative got %h c=%b z=%b want ffffffff c=0 z=0", res, co, z);
        end
        do_op(1'b1, 32'h12345678, 32'h12345678, 0, res, co, z, dk, dc, bc, cb);
        checks++;
        if ({res, co, z} !== {32'h00000000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sub_equal got %h c=%b z=%b want 00000000 c=1 z=1", res, co, z);
        end
        checks++;
        if (cb !== 0) begin
            errors++; $display("FAIL sub_ctrl got %0d bad RUN cycles want 0", cb);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; logic co, z; int dk, dc, bc, cb;
        do_op(1'b0, 32'h11223344, 32'h01010101, 1, res, co, z, dk, dc, bc, cb);
        checks++;
        if (dc !== 1 || bc !== W + 1) begin
            errors++; $display("FAIL b2b_single_done got pulses=%0d busy=%0d want 1/%0d", dc, bc, W + 1);
        end
        checks++;
        if ({res, co, z} !== {32'h12233445, 1'b0, 1'b0}) begin
            errors++; $display("FAIL b2b_result got %h c=%b z=%b want 12233445 c=0 z=0", res, co, z);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] res; logic co, z; int dk, dc, bc, cb; int seen_done;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.opA = 32'h0A0B0C0D; bus.opB = 32'h01020304;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00 || bus.result !== 32'h0) begin
            errors++; $display("FAIL abort_state got busy=%b done=%b res=%h want 0/0/00000000",
                               bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL abort_no_done got %0d active cycles want 0", seen_done);
        end
        do_op(1'b0, 32'h00000002, 32'h00000003, 0, res, co, z, dk, dc, bc, cb);
        checks++;
        if ({res, co, z} !== {32'h00000005, 1'b0, 1'b0} || dk !== W) begin
            errors++; $display("FAIL after_abort got %h c=%b z=%b done_at=%0d want 00000005 c=0 z=0 %0d",
                               res, co, z, dk, W);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
